// File: rtl/pend_enc32.sv
// pend_enc32 -- pending-bit priority encoder.
//
// Collects multi-hot request pulses into a pending vector P and presents
// one pending index at a time on a valid/ready output. It does the reverse
// of a register-select decoder.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   req_in      [31:0] request pulses; each set bit marks that index pending
//   out_ready   consumer accepts the presented index
//   out_valid   out_idx holds a valid pending index
//   out_idx     [4:0] binary index currently presented
//   pending     [31:0] registered pending vector P
//   pend_cnt    [5:0] registered popcount of P (0..32)
//   dup_err     sticky flag: a request hit an already-pending bit
//   dbg_state_o current FSM state (0 = IDLE, 1 = PRESENT)
//
// Handshake: an index transfers on any rising edge where out_valid and
// out_ready are both 1. out_valid, once raised, stays raised and out_idx
// stays stable until that transfer happens. out_ready is ignored while
// out_valid is 0.
module pend_enc32 #(
  parameter bit HI_FIRST = 1'b0  // 0: lowest pending index wins, 1: highest
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic [31:0] pending,
  output logic [5:0]  pend_cnt,
  output logic        dup_err,
  output logic        dbg_state_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] p_q;
  logic [31:0] p_d;
  logic [4:0]  idx_q;
  logic [5:0]  cnt_q;
  logic        dup_q;

  logic        acc;
  logic [31:0] acc_mask;
  logic        dup_hit;

  // Priority encode. The loop direction decides which set bit assigns last,
  // and therefore which one wins.
  function automatic logic [4:0] enc(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    if (HI_FIRST) begin
      for (int i = 0; i < 32; i++) begin
        if (v[i]) r = 5'(i);
      end
    end else begin
      for (int i = 31; i >= 0; i--) begin
        if (v[i]) r = 5'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [5:0] popcnt(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

  always_comb begin
    acc      = (state_q == PRESENT) && out_ready;
    acc_mask = acc ? (32'd1 << idx_q) : 32'd0;
    // The request OR comes after the accept clear. A request for the index
    // being accepted on the same edge therefore stays pending.
    p_d      = (p_q & ~acc_mask) | req_in;
    // A bit that is being accepted on this edge is not a duplicate.
    dup_hit  = |(req_in & p_q & ~acc_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      p_q   <= p_d;
      cnt_q <= popcnt(p_d);
      if (dup_hit) dup_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (|p_d) begin
            idx_q   <= enc(p_d);
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          // Hold steady until accepted. On the accept edge, the next index
          // comes from P_next so that back-to-back transfers have no bubble.
          if (acc) begin
            if (|p_d) idx_q <= enc(p_d);
            else      state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = (state_q == PRESENT);
  assign out_idx     = idx_q;
  assign pending     = p_q;
  assign pend_cnt    = cnt_q;
  assign dup_err     = dup_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/pend_enc32.md
PEND_ENC32 -- requirements
Module: pend_enc32

Interface
REQ-001 SHALL have parameter: HI_FIRST, default 0, 0 = lowest pending index wins, 1 = highest pending index wins.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_in  input  32  one-hot/multi-hot request pulses, each set bit marks that index pending.
REQ-005 SHALL have port: out_ready  input  1  consumer accepts presented index.
REQ-006 SHALL have port: out_valid  output  1  out_idx holds a valid pending index.
REQ-007 SHALL have port: out_idx  output  5  binary-encoded presented index.
REQ-008 SHALL have port: pending  output  32  registered pending-bit vector P.
REQ-009 SHALL have port: pend_cnt  output  6  registered count of set bits in P, range 0..32.
REQ-010 SHALL have port: dup_err  output  1  sticky duplicate-request flag.

Function
REQ-011 SHALL be the inverse of the register-select decoder: it converts a multi-hot request vector into a stream of 5-bit indices, one per handshake.
REQ-012 SHALL define the handshake as: accept occurs on any edge where out_valid=1 and out_ready=1.
REQ-013 SHALL update P on every edge as: P_next = (P & ~acc_mask) | req_in. acc_mask is the one-hot of out_idx on an accept edge and zero otherwise.
REQ-014 SHALL give set priority: a req_in bit equal to the accepted index on the same edge leaves that bit set in P_next.
REQ-015 SHALL implement the FSM with two states. IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-016 SHALL, in IDLE, load out_idx = enc(P | req_in) and move to PRESENT on the edge where (P | req_in) is nonzero. Otherwise it SHALL stay in IDLE with out_idx unchanged.
REQ-017 SHALL keep out_idx and out_valid stable while in PRESENT with out_ready=0, even if a higher-priority request arrives.
REQ-018 SHALL, on an accept edge, load out_idx = enc(P_next) and stay in PRESENT if P_next is nonzero. Otherwise it SHALL go to IDLE, with out_idx holding its last value. No bubble cycle is allowed between back-to-back indices.
REQ-019 SHALL compute enc() as the index of the lowest set bit when HI_FIRST=0, and of the highest set bit when HI_FIRST=1.
REQ-020 SHALL keep the presented index's bit set in P until it is accepted.
REQ-021 SHALL give request-to-valid latency of one edge: req_in sampled at edge k means out_valid=1 in the cycle after edge k.
REQ-022 SHALL register pend_cnt = popcount(P_next) each edge. pend_cnt SHALL always equal popcount(pending).
REQ-023 SHALL set dup_err on an edge where any req_in bit is already set in P and is not being cleared by an accept that same edge. dup_err SHALL then hold 1 until reset.
REQ-024 SHALL handle a duplicate request without changing P, other than the OR in REQ-013. A duplicate is not queued twice.
REQ-025 SHALL ignore out_ready while out_valid=0.
REQ-026 SHALL raise all 32 bits simultaneously when req_in=32'hFFFF_FFFF from empty. It SHALL then give pend_cnt=32 and drain in 32 consecutive accepts when out_ready is held at 1.

Reset
REQ-027 SHALL, on an edge with reset=1, set P=0, pend_cnt=0, out_valid=0, out_idx=0, dup_err=0, FSM=IDLE, ignoring req_in and out_ready that edge.
REQ-028 SHALL discard any presented but unaccepted index on a mid-operation reset. After the reset edge, no output SHALL reflect prior state.

Verification
REQ-029 SHALL cover: reset, then req_in=32'h0000_0010 for one cycle with out_ready=0 -> next cycle out_valid=1, out_idx=4, pending=32'h10, pend_cnt=1.
REQ-030 SHALL cover: HI_FIRST=0, req_in=32'h8000_0005 in one cycle, out_ready=1 held -> out_idx sequence 0,2,31 on consecutive cycles, then out_valid=0, pend_cnt 3,2,1,0.
REQ-031 SHALL cover: index 7 presented, out_ready=0, req_in=32'h2 arrives -> out_idx stays 7 until accept, then becomes 1.
REQ-032 SHALL cover: index 3 presented and accepted on the same edge req_in=32'h8 -> pending bit 3 remains 1, dup_err=0, out_idx=3 again next cycle.
REQ-033 SHALL cover: pending=32'h40 with no accept, req_in=32'h40 -> dup_err=1 and stays 1; pend_cnt remains 1.
REQ-034 SHALL cover: pend_cnt=5 and out_valid=1, then reset=1 for one edge -> pending=0, pend_cnt=0, out_valid=0, out_idx=0, dup_err=0.
